// File: rtl/rdmem_burst_scheduler_if.sv
// Bus bundle for rdmem_burst_scheduler: host table writes, session control,
// shared memory read port and per-port consumer strobes.
interface rdmem_burst_scheduler_if #(
  parameter int PORT_W = 2,
  parameter int AW     = 16,
  parameter int LW     = 16
);
  localparam int NPORT = 2 ** PORT_W;

  logic              cfg_we;
  logic [PORT_W-1:0] cfg_port;
  logic [AW-1:0]     cfg_base;
  logic [LW-1:0]     cfg_len;
  logic              go;
  logic              exists;
  logic [NPORT-1:0]  in_rdy;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic [PORT_W-1:0] sel;
  logic [NPORT-1:0]  send;
  logic              busy;
  logic              done;

  modport master (
    output cfg_we, cfg_port, cfg_base, cfg_len, go, exists, in_rdy,
    input  mem_rd, mem_addr, sel, send, busy, done
  );

  modport slave (
    input  cfg_we, cfg_port, cfg_base, cfg_len, go, exists, in_rdy,
    output mem_rd, mem_addr, sel, send, busy, done
  );
endinterface

// File: rtl/rdmem_burst_scheduler.sv
// Shares one memory read port among NPORT stream ports in bursts of up to BURST words.
// Define RDMEM_SCHED_PRIO_EN for fixed lowest-index-first arbitration instead of round-robin.
//
// state | meaning
// IDLE  | no session; table writable, waiting for go
// ARB   | searching for a port with act && in_rdy
// XFER  | read port granted to sel; one word per exists && in_rdy[sel]
// NEXT  | burst finished; retire drained port, end session or re-arbitrate
module rdmem_burst_scheduler #(
  parameter int PORT_W = 2,
  parameter int AW     = 16,
  parameter int LW     = 16,
  parameter int BURST  = 8
) (
  input logic clk,
  input logic rst,
  rdmem_burst_scheduler_if.slave bus
);
  localparam int NPORT = 2 ** PORT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_XFER,
    S_NEXT
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]     ptr [NPORT];
  logic [LW-1:0]     rem [NPORT];
  logic [NPORT-1:0]  act;
  logic [PORT_W-1:0] sel;
  logic [LW-1:0]     bleft;
  logic              empty_go_q;
`ifndef RDMEM_SCHED_PRIO_EN
  logic [PORT_W-1:0] last;
  logic [PORT_W-1:0] rr_idx;
`endif

  logic              busy_int;
  logic              fin;
  logic              cfg_ok;
  logic              xfer;
  logic              last_word;
  logic              burst_end;
  logic              hit;
  logic [PORT_W-1:0] pick;
  logic [NPORT-1:0]  elig;
  logic [NPORT-1:0]  act_cfg;
  logic [NPORT-1:0]  act_next;

  assign elig      = act & bus.in_rdy;
  assign xfer      = (state == S_XFER) && bus.exists && bus.in_rdy[sel];
  assign last_word = (rem[sel] == LW'(1));
  assign burst_end = (bleft == LW'(1));
  assign fin       = (state == S_NEXT) && (act_next == '0);
  assign busy_int  = (state != S_IDLE) && !fin;
  assign cfg_ok    = bus.cfg_we && !busy_int;

  // act as go will see it: a write in the same cycle lands first
  always_comb begin
    act_cfg = act;
    if (cfg_ok) begin
      act_cfg[bus.cfg_port] = (bus.cfg_len != '0);
    end
  end

  always_comb begin
    act_next = act;
    if ((state == S_NEXT) && (rem[sel] == '0)) begin
      act_next[sel] = 1'b0;
    end
  end

`ifdef RDMEM_SCHED_PRIO_EN
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (elig[i]) begin
        hit  = 1'b1;
        pick = PORT_W'(i);
      end
    end
  end
`else
  // Walk candidates from farthest to nearest so last+1 ends up winning.
  always_comb begin
    hit    = 1'b0;
    pick   = '0;
    rr_idx = '0;
    for (int k = NPORT; k >= 1; k--) begin
      rr_idx = last + PORT_W'(k);
      if (elig[rr_idx]) begin
        hit  = 1'b1;
        pick = rr_idx;
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.go && (act_cfg != '0)) begin
          state_nxt = S_ARB;
        end
      end
      S_ARB: begin
        if (hit) begin
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (!bus.in_rdy[sel]) begin
          state_nxt = S_ARB;
        end else if (xfer && (burst_end || last_word)) begin
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        state_nxt = (act_next == '0) ? S_IDLE : S_ARB;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      act        <= '0;
      sel        <= '0;
      bleft      <= '0;
      empty_go_q <= 1'b0;
`ifndef RDMEM_SCHED_PRIO_EN
      last       <= '1;
`endif
      for (int i = 0; i < NPORT; i++) begin
        ptr[i] <= '0;
        rem[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      empty_go_q <= (state == S_IDLE) && bus.go && (act_cfg == '0);
      act        <= act_next;

      if ((state == S_ARB) && hit) begin
        sel   <= pick;
        bleft <= LW'(BURST);
`ifndef RDMEM_SCHED_PRIO_EN
        last  <= pick;
`endif
      end

      if (xfer) begin
        ptr[sel] <= ptr[sel] + AW'(1);
        rem[sel] <= rem[sel] - LW'(1);
        bleft    <= bleft - LW'(1);
      end

      // placed last so a host write wins over the retire clear in the final NEXT cycle
      if (cfg_ok) begin
        ptr[bus.cfg_port] <= bus.cfg_base;
        rem[bus.cfg_port] <= bus.cfg_len;
        act[bus.cfg_port] <= (bus.cfg_len != '0);
      end
    end
  end

  assign bus.mem_rd   = xfer;
  assign bus.send     = xfer ? (NPORT'(1) << sel) : '0;
  assign bus.mem_addr = ptr[sel];
  assign bus.sel      = sel;
  assign bus.busy     = busy_int;
  assign bus.done     = fin || empty_go_q;
endmodule

// File: tb/tb_rdmem_burst_scheduler.sv
// Scenario bench for rdmem_burst_scheduler: expected reads are queued as stimulus is
// set up and matched against reads captured from the read port.
module tb_rdmem_burst_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rdmem_burst_scheduler_if #(.PORT_W(2), .AW(16), .LW(16)) bus ();

  rdmem_burst_scheduler #(.PORT_W(2), .AW(16), .LW(16), .BURST(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {logic [3:0] send; logic [1:0] sel; logic [15:0] addr; int gap;} exp_t;
  typedef struct {logic [3:0] send; logic [1:0] sel; logic [15:0] addr; int cyc;} obs_t;
  typedef struct {int cyc; logic busy;} dn_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  dn_t  dn_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    if (bus.mem_rd === 1'b1) obs_q.push_back('{bus.send, bus.sel, bus.mem_addr, cyc});
    if (bus.done === 1'b1) dn_q.push_back('{cyc, bus.busy});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_port = '0; bus.cfg_base = '0; bus.cfg_len = '0;
    bus.go = 1'b0; bus.exists = 1'b0; bus.in_rdy = '0;
    step();
    step();
    rst = 1'b0;
    obs_q.delete(); exp_q.delete(); dn_q.delete();
  endtask

  task automatic cfg_write(input int port, input int base, input int len);
    bus.cfg_we = 1'b1; bus.cfg_port = 2'(port); bus.cfg_base = 16'(base); bus.cfg_len = 16'(len);
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic push_exp(input int port, input int addr, input int gap);
    exp_q.push_back('{4'(1 << port), 2'(port), 16'(addr), gap});
  endtask

  task automatic wait_done(input int budget, output int dcyc, output logic dbusy, output bit ok);
    dn_t d;
    ok = 1'b0; dcyc = -1; dbusy = 1'bx;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (dn_q.size() > 0) begin
        d = dn_q.pop_front();
        ok = 1'b1; dcyc = d.cyc; dbusy = d.busy;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, want 0", bus.done); end
    n_tests++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b, want 0", bus.mem_rd); end
    n_tests++; if (bus.send !== 4'b0000) begin n_fail++; $display("FAIL reset_send: got %b, want 0000", bus.send); end
    n_tests++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h, want 0000", bus.mem_addr); end
    n_tests++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d, want 0", bus.sel); end
    step();
  endtask

  task automatic test_single();
    int k, prev, dcyc; logic dbusy; bit ok; exp_t e; obs_t o;
    do_reset();
    bus.exists = 1'b1; bus.in_rdy = 4'hF;
    cfg_write(0, 'h100, 5);
    for (int i = 0; i < 5; i++) push_exp(0, 'h100 + i, (i == 0) ? 2 : 1);
    bus.go = 1'b1; k = cyc; step(); bus.go = 1'b0;
    wait_done(60, dcyc, dbusy, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_done: got no done in 60 cycles, want a pulse"); end
    prev = k;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL single_rd: got no read, want addr %h", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o.send !== e.send || o.sel !== e.sel || o.addr !== e.addr || o.cyc - prev !== e.gap) begin
          n_fail++;
          $display("FAIL single_rd: got send=%b sel=%0d addr=%h gap=%0d, want send=%b sel=%0d addr=%h gap=%0d",
                   o.send, o.sel, o.addr, o.cyc - prev, e.send, e.sel, e.addr, e.gap);
        end
        prev = o.cyc;
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL single_extra: got %0d extra reads, want 0", obs_q.size()); end
    n_tests++; if (dcyc !== prev + 1 || dbusy !== 1'b0) begin n_fail++; $display("FAIL single_done_t: got cycle %0d busy %b, want cycle %0d busy 0", dcyc, dbusy, prev + 1); end
  endtask

  task automatic test_two_ports();
    int k, prev, dcyc; logic dbusy; bit ok; exp_t e; obs_t o;
    do_reset();
    bus.exists = 1'b1; bus.in_rdy = 4'hF;
    cfg_write(0, 'h200, 10);
    cfg_write(1, 'h300, 10);
`ifdef RDMEM_SCHED_PRIO_EN
    for (int i = 0; i < 10; i++) push_exp(0, 'h200 + i, (i == 0) ? 2 : (i == 8) ? 3 : 1);
    for (int i = 0; i < 10; i++) push_exp(1, 'h300 + i, (i == 0 || i == 8) ? 3 : 1);
`else
    for (int i = 0; i < 8; i++) push_exp(0, 'h200 + i, (i == 0) ? 2 : 1);
    for (int i = 0; i < 8; i++) push_exp(1, 'h300 + i, (i == 0) ? 3 : 1);
    push_exp(0, 'h208, 3); push_exp(0, 'h209, 1);
    push_exp(1, 'h308, 3); push_exp(1, 'h309, 1);
`endif
    bus.go = 1'b1; k = cyc; step(); bus.go = 1'b0;
    wait_done(100, dcyc, dbusy, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL two_done: got no done in 100 cycles, want a pulse"); end
    prev = k;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL two_rd: got no read, want addr %h", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o.send !== e.send || o.sel !== e.sel || o.addr !== e.addr || o.cyc - prev !== e.gap) begin
          n_fail++;
          $display("FAIL two_rd: got send=%b sel=%0d addr=%h gap=%0d, want send=%b sel=%0d addr=%h gap=%0d",
                   o.send, o.sel, o.addr, o.cyc - prev, e.send, e.sel, e.addr, e.gap);
        end
        prev = o.cyc;
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL two_extra: got %0d extra reads, want 0", obs_q.size()); end
    n_tests++; if (dcyc !== prev + 1 || dbusy !== 1'b0) begin n_fail++; $display("FAIL two_done_t: got cycle %0d busy %b, want cycle %0d busy 0", dcyc, dbusy, prev + 1); end
  endtask

  task automatic test_exists_toggle();
    int cnt, last_t; logic exp_rd, exp_done;
    do_reset();
    bus.exists = 1'b0; bus.in_rdy = 4'hF;
    cfg_write(0, 'h40, 3);
    bus.go = 1'b1; cnt = 0; last_t = -10;
    for (int t = 0; t < 14; t++) begin
      if (t == 1) bus.go = 1'b0;
      bus.exists = (t % 2 == 1);
      @(negedge clk);
      exp_rd   = bus.exists && (t >= 2) && (cnt < 3);
      exp_done = (cnt == 3) && (t == last_t + 1);
      n_tests++;
      if (bus.mem_rd !== exp_rd || bus.send !== (exp_rd ? 4'b0001 : 4'b0000) ||
          bus.mem_addr !== 16'('h40 + cnt) || bus.done !== exp_done) begin
        n_fail++;
        $display("FAIL exists_t%0d: got rd=%b send=%b addr=%h done=%b, want rd=%b send=%b addr=%h done=%b",
                 t, bus.mem_rd, bus.send, bus.mem_addr, bus.done, exp_rd, exp_rd ? 4'b0001 : 4'b0000,
                 16'('h40 + cnt), exp_done);
      end
      if (exp_rd) begin cnt++; last_t = t; end
      step();
    end
    n_tests++; if (cnt != 3) begin n_fail++; $display("FAIL exists_count: got %0d transfers, want 3", cnt); end
  endtask

  task automatic test_rdy_drop();
    int k, prev, dcyc; logic dbusy; bit ok; exp_t e; obs_t o;
    do_reset();
    bus.exists = 1'b1; bus.in_rdy = 4'hF;
    cfg_write(0, 'h500, 10);
    cfg_write(1, 'h600, 4);
    for (int i = 0; i < 3; i++) push_exp(0, 'h500 + i, (i == 0) ? 2 : 1);
    for (int i = 0; i < 4; i++) push_exp(1, 'h600 + i, (i == 0) ? 3 : 1);
    for (int i = 0; i < 7; i++) push_exp(0, 'h503 + i, (i == 0) ? 5 : 1);
    bus.go = 1'b1; k = cyc; step(); bus.go = 1'b0;
    repeat (4) step();
    bus.in_rdy = 4'b1110;
    repeat (9) step();
    bus.in_rdy = 4'hF;
    wait_done(60, dcyc, dbusy, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL drop_done: got no done in 60 cycles, want a pulse"); end
    prev = k;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL drop_rd: got no read, want addr %h", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o.send !== e.send || o.sel !== e.sel || o.addr !== e.addr || o.cyc - prev !== e.gap) begin
          n_fail++;
          $display("FAIL drop_rd: got send=%b sel=%0d addr=%h gap=%0d, want send=%b sel=%0d addr=%h gap=%0d",
                   o.send, o.sel, o.addr, o.cyc - prev, e.send, e.sel, e.addr, e.gap);
        end
        prev = o.cyc;
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL drop_extra: got %0d extra reads, want 0", obs_q.size()); end
    n_tests++; if (dcyc !== prev + 1) begin n_fail++; $display("FAIL drop_done_t: got cycle %0d, want %0d", dcyc, prev + 1); end
  endtask

  task automatic test_empty_go();
    int k, dcyc; logic dbusy; bit ok;
    do_reset();
    bus.exists = 1'b1; bus.in_rdy = 4'hF;
    cfg_write(0, 'h10, 0);
    bus.go = 1'b1; k = cyc;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy0: got %b, want 0", bus.busy); end
    step(); bus.go = 1'b0;
    wait_done(10, dcyc, dbusy, ok);
    n_tests++; if (!ok || dcyc !== k + 1 || dbusy !== 1'b0) begin n_fail++; $display("FAIL empty_done: got ok=%b cycle %0d busy %b, want ok=1 cycle %0d busy 0", ok, dcyc, dbusy, k + 1); end
    repeat (5) step();
    n_tests++; if (obs_q.size() != 0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL empty_idle: got %0d reads busy %b, want 0 reads busy 0", obs_q.size(), bus.busy); end
  endtask

  task automatic test_cfg_busy();
    int k, prev, dcyc; logic dbusy; bit ok; exp_t e; obs_t o;
    do_reset();
    bus.exists = 1'b1; bus.in_rdy = 4'hF;
    cfg_write(0, 'h700, 3);
    for (int i = 0; i < 3; i++) push_exp(0, 'h700 + i, (i == 0) ? 2 : 1);
    bus.go = 1'b1; k = cyc; step(); bus.go = 1'b0;
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL cfgbusy_busy: got %b, want 1", bus.busy); end
    bus.cfg_we = 1'b1; bus.cfg_port = 2'd1; bus.cfg_base = 16'h0800; bus.cfg_len = 16'd5;
    step();
    bus.cfg_port = 2'd0; bus.cfg_base = 16'h0900; bus.cfg_len = 16'd9;
    step();
    bus.cfg_we = 1'b0;
    wait_done(40, dcyc, dbusy, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL cfgbusy_done: got no done in 40 cycles, want a pulse"); end
    prev = k;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL cfgbusy_rd: got no read, want addr %h", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o.send !== e.send || o.sel !== e.sel || o.addr !== e.addr || o.cyc - prev !== e.gap) begin
          n_fail++;
          $display("FAIL cfgbusy_rd: got send=%b sel=%0d addr=%h gap=%0d, want send=%b sel=%0d addr=%h gap=%0d",
                   o.send, o.sel, o.addr, o.cyc - prev, e.send, e.sel, e.addr, e.gap);
        end
        prev = o.cyc;
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL cfgbusy_extra: got %0d extra reads, want 0", obs_q.size()); end
  endtask

  task automatic test_cfg_go_same();
    int k, prev, dcyc; logic dbusy; bit ok; exp_t e; obs_t o;
    do_reset();
    bus.exists = 1'b1; bus.in_rdy = 4'hF;
    push_exp(2, 'h50, 2);
    push_exp(2, 'h51, 1);
    bus.cfg_we = 1'b1; bus.cfg_port = 2'd2; bus.cfg_base = 16'h0050; bus.cfg_len = 16'd2;
    bus.go = 1'b1; k = cyc; step();
    bus.cfg_we = 1'b0; bus.go = 1'b0;
    wait_done(30, dcyc, dbusy, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL samecyc_done: got no done in 30 cycles, want a pulse"); end
    prev = k;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL samecyc_rd: got no read, want addr %h", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o.send !== e.send || o.sel !== e.sel || o.addr !== e.addr || o.cyc - prev !== e.gap) begin
          n_fail++;
          $display("FAIL samecyc_rd: got send=%b sel=%0d addr=%h gap=%0d, want send=%b sel=%0d addr=%h gap=%0d",
                   o.send, o.sel, o.addr, o.cyc - prev, e.send, e.sel, e.addr, e.gap);
        end
        prev = o.cyc;
      end
    end
    n_tests++; if (dcyc !== prev + 1) begin n_fail++; $display("FAIL samecyc_done_t: got cycle %0d, want %0d", dcyc, prev + 1); end
  endtask

  task automatic test_reset_mid();
    int k, dcyc; logic dbusy; bit ok;
    do_reset();
    bus.exists = 1'b1; bus.in_rdy = 4'hF;
    cfg_write(0, 'hA00, 10);
    bus.go = 1'b1; step(); bus.go = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_rd !== 1'b0 || bus.send !== 4'b0000 ||
        bus.mem_addr !== 16'h0000 || bus.sel !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_outs: got busy=%b done=%b rd=%b send=%b addr=%h sel=%0d, want all 0",
               bus.busy, bus.done, bus.mem_rd, bus.send, bus.mem_addr, bus.sel);
    end
    n_tests++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL midrst_pre: got %0d reads before reset, want 3", obs_q.size()); end
    obs_q.delete(); dn_q.delete();
    repeat (6) step();
    n_tests++; if (dn_q.size() != 0 || obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d done %0d reads, want 0 and 0", dn_q.size(), obs_q.size()); end
    bus.go = 1'b1; k = cyc; step(); bus.go = 1'b0;
    wait_done(10, dcyc, dbusy, ok);
    n_tests++; if (!ok || dcyc !== k + 1) begin n_fail++; $display("FAIL midrst_table: got ok=%b done cycle %0d, want ok=1 cycle %0d", ok, dcyc, k + 1); end
    repeat (3) step();
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_noread: got %0d reads, want 0", obs_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time 200000, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_two_ports();
    test_exists_toggle();
    test_rdy_drop();
    test_empty_go();
    test_cfg_busy();
    test_cfg_go_same();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
